// File: rtl/mips_exec_unit.sv
// Single-cycle MIPS decode + ALU + word data memory + write-back mux; all combinational except stores (at clk edge).
// No backpressure. Optional range check via EXEC_DMEM_RANGE_CHECK_EN (flags and suppresses out-of-range accesses).
module mips_exec_unit #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic [31:0] src_a,
  input  logic [31:0] rd2,
  input  logic [31:0] sign_imm,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        branch,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        jump,
  output logic [2:0]  alu_control,
  output logic        illegal,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        pc_src,
  output logic [31:0] read_data,
  output logic [31:0] result,
  output logic        addr_err
);

  logic [1:0]    alu_op;
  logic [31:0]   alu_b;
  logic [AW-1:0] mem_idx;
  logic          mem_we;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];

  always_comb begin
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    jump       = 1'b0;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    case (op)
      6'b000000: begin reg_write = 1'b1; reg_dst = 1'b1; alu_op = 2'b10; end
      6'b100011: begin reg_write = 1'b1; alu_src = 1'b1; mem_to_reg = 1'b1; end
      6'b101011: begin alu_src = 1'b1; mem_write = 1'b1; end
      6'b000100: begin branch = 1'b1; alu_op = 2'b01; end
      6'b001000: begin reg_write = 1'b1; alu_src = 1'b1; end
      6'b000010: jump = 1'b1;
      default:   illegal = 1'b1;
    endcase

    alu_control = 3'b010;
    case (alu_op)
      2'b01: alu_control = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alu_control = 3'b010;
          6'b100010: alu_control = 3'b110;
          6'b100100: alu_control = 3'b000;
          6'b100101: alu_control = 3'b001;
          6'b101010: alu_control = 3'b111;
          default: begin
            // Unknown funct must not corrupt the register file.
            illegal   = 1'b1;
            reg_write = 1'b0;
          end
        endcase
      end
      default: alu_control = 3'b010;
    endcase
  end

  always_comb begin
    alu_b = alu_src ? sign_imm : rd2;
    case (alu_control)
      3'b000:  alu_result = src_a & alu_b;
      3'b001:  alu_result = src_a | alu_b;
      3'b010:  alu_result = src_a + alu_b;
      3'b100:  alu_result = src_a & ~alu_b;
      3'b101:  alu_result = src_a | ~alu_b;
      3'b110:  alu_result = src_a - alu_b;
      3'b111:  alu_result = ($signed(src_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    zero   = (alu_result == 32'd0);
    pc_src = branch & zero;
  end

  assign mem_idx = alu_result[AW+1:2];

`ifdef EXEC_DMEM_RANGE_CHECK_EN
  assign addr_err = (|alu_result[31:AW+2]) & (mem_write | mem_to_reg);
`else
  assign addr_err = 1'b0;
`endif

  assign mem_we    = mem_write & ~addr_err;
  assign read_data = addr_err ? 32'd0 : mem_q[mem_idx];
  assign result    = mem_to_reg ? read_data : alu_result;

  always_comb begin
    mem_d = mem_q;
    if (mem_we) mem_d[mem_idx] = rd2;
  end

  // Reset clears every word and overrides any store on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_mips_exec_unit.sv
// Directed plan steps followed by randomized instructions, all checked against a behavioural model.
module tb_mips_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op, funct;
  logic [31:0] src_a, rd2, sign_imm;
  logic        reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg, jump;
  logic [2:0]  alu_control;
  logic        illegal, zero, pc_src, addr_err;
  logic [31:0] alu_result, read_data, result;

  int checks = 0;
  int failures = 0;
  logic [31:0] ref_mem [64];

  always #5 clk = ~clk;

  mips_exec_unit #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .src_a(src_a), .rd2(rd2),
    .sign_imm(sign_imm), .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
    .branch(branch), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .jump(jump),
    .alu_control(alu_control), .illegal(illegal), .alu_result(alu_result), .zero(zero),
    .pc_src(pc_src), .read_data(read_data), .result(result), .addr_err(addr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one instruction mid-cycle, check every output, then fold the store/reset into the model.
  task automatic step(input logic [5:0] o, input logic [5:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm, input logic r);
    logic rw, rdst, asrc, br, mw, m2r, jp, ill, err;
    logic [2:0]  ctl;
    logic [31:0] bb, alu, rdat, res;
    string kind;
    int idx;
    @(negedge clk);
    op = o; funct = f; src_a = a; rd2 = b; sign_imm = imm; rst_n = r;
    #1;
    {rw, rdst, asrc, br, mw, m2r, jp, ill} = '0;
    kind = "add";
    case (o)
      6'd0: begin
        rw = 1; rdst = 1;
        if (f == 6'd32) kind = "add";
        else if (f == 6'd34) kind = "sub";
        else if (f == 6'd36) kind = "and";
        else if (f == 6'd37) kind = "or";
        else if (f == 6'd42) kind = "slt";
        else begin ill = 1; rw = 0; end
      end
      6'd35: begin rw = 1; asrc = 1; m2r = 1; end
      6'd43: begin asrc = 1; mw = 1; end
      6'd4:  begin br = 1; kind = "sub"; end
      6'd8:  begin rw = 1; asrc = 1; end
      6'd2:  jp = 1;
      default: ill = 1;
    endcase
    bb = asrc ? imm : b;
    if (kind == "sub")      begin alu = a - bb;  ctl = 3'b110; end
    else if (kind == "and") begin alu = a & bb;  ctl = 3'b000; end
    else if (kind == "or")  begin alu = a | bb;  ctl = 3'b001; end
    else if (kind == "slt") begin alu = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0; ctl = 3'b111; end
    else                    begin alu = a + bb;  ctl = 3'b010; end
    idx = int'((alu / 4) % 64);
`ifdef EXEC_DMEM_RANGE_CHECK_EN
    err = (alu >= 32'd256) && (mw || m2r);
`else
    err = 1'b0;
`endif
    rdat = err ? 32'd0 : ref_mem[idx];
    res  = m2r ? rdat : alu;
    chk("ctrl", {22'd0, reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg, jump, alu_control},
                {22'd0, rw, rdst, asrc, br, mw, m2r, jp, ctl});
    chk("illegal", {31'd0, illegal}, {31'd0, ill});
    chk("alu_result", alu_result, alu);
    chk("zero_pc_src", {30'd0, zero, pc_src}, {30'd0, alu == 0, br && alu == 0});
    chk("read_data", read_data, rdat);
    chk("result", result, res);
    chk("addr_err", {31'd0, addr_err}, {31'd0, err});
    if (!r) begin
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
    end else if (mw && !err) begin
      ref_mem[idx] = b;
    end
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] fns [5];
    logic [5:0] o, f;
    logic [31:0] a, imm;
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2, 6'd63, 6'd13};
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    op = 0; funct = 0; src_a = 0; rd2 = 0; sign_imm = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;

    // Memory is clear after reset.
    step(6'd35, 6'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    chk("reset_word0", read_data, 32'd0);
    step(6'd35, 6'd0, 32'd252, 32'd0, 32'd0, 1'b1);
    chk("reset_word63", read_data, 32'd0);

    step(6'd0, 6'b100010, 32'd5, 32'd7, 32'd0, 1'b1);
    chk("rtype_sub_res", result, 32'hFFFF_FFFE);
    chk("rtype_sub_ctl", {29'd0, alu_control}, 32'd6);
    step(6'd0, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    chk("slt_neg", alu_result, 32'd1);
    step(6'd0, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
    chk("slt_pos", alu_result, 32'd0);

    step(6'd43, 6'd0, 32'h10, 32'hDEAD_BEEF, 32'd4, 1'b1);
    chk("sw_same_cycle_old", read_data, 32'd0);
    step(6'd35, 6'd0, 32'h10, 32'd0, 32'd4, 1'b1);
    chk("lw_after_sw", result, 32'hDEAD_BEEF);

    step(6'd4, 6'd0, 32'd9, 32'd9, 32'd0, 1'b1);
    chk("beq_taken", {31'd0, pc_src}, 32'd1);
    step(6'd4, 6'd0, 32'd9, 32'd8, 32'd0, 1'b1);
    chk("beq_not_taken", {31'd0, pc_src}, 32'd0);

    step(6'd43, 6'd0, 32'd12, 32'h1234, 32'd0, 1'b1);
    step(6'd43, 6'd0, 32'd12, 32'h5555, 32'd0, 1'b0);
    step(6'd35, 6'd0, 32'd12, 32'd0, 32'd0, 1'b1);
    chk("reset_beats_store", read_data, 32'd0);

    step(6'd43, 6'd0, 32'd20, 32'h1, 32'd0, 1'b1);
    step(6'd43, 6'd0, 32'd20, 32'h2, 32'd0, 1'b1);
    step(6'd35, 6'd0, 32'd20, 32'd0, 32'd0, 1'b1);
    chk("back_to_back_last", read_data, 32'h2);

    step(6'b111111, 6'd0, 32'd3, 32'd4, 32'd0, 1'b1);
    chk("illegal_op", {29'd0, illegal, reg_write, mem_write}, 32'b100);

    step(6'd43, 6'd0, 32'd0, 32'h1111, 32'd0, 1'b1);
    step(6'd43, 6'd0, 32'h400, 32'hCAFE, 32'd0, 1'b1);
    step(6'd35, 6'd0, 32'd0, 32'd0, 32'd0, 1'b1);
`ifdef EXEC_DMEM_RANGE_CHECK_EN
    chk("range_store_dropped", read_data, 32'h1111);
`else
    chk("wrap_store_word0", read_data, 32'hCAFE);
`endif

    for (int n = 0; n < 400; n++) begin
      o = ops[$urandom_range(0, 7)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      if ((o == 6'd35 || o == 6'd43) && $urandom_range(0, 7) != 0) begin
        a   = $urandom_range(0, 255);
        imm = $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
      end else begin
        a   = $urandom;
        imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(16'($urandom)));
      end
      step(o, f, a, $urandom, imm, ($urandom_range(0, 49) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
